// File: rtl/spm_fill_ctrl_pkg.sv
// Shared definitions for the SPM port-B fill controller: strobe/direction
// encodings, default widths and the fill FSM state type.
package spm_fill_ctrl_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int SPM_ADDR_W     = 12;
  localparam int SPM_DATA_W     = 32;
  localparam int STARVE_MAX_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/spm_fill_ctrl.sv
// SPM port-B owner: shares the port between the MEM stage and a block-fill
// engine that writes a (constant or incrementing) pattern into idle cycles.
//
// state | meaning
// IDLE  | engine parked, port B follows the MEM stage
// FILL  | engine writes one word per cycle the MEM stage leaves port B idle
// DONE  | single cycle after the last write, done_irq asserted
module spm_fill_ctrl
  import spm_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W     = SPM_ADDR_W,
  parameter int DATA_W     = SPM_DATA_W,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_spm_addr,
  input  logic              mem_spm_as_,
  input  logic              mem_spm_rw,
  input  logic [DATA_W-1:0] mem_spm_wr_data,
  output logic [DATA_W-1:0] mem_spm_rd_data,
  output logic              mem_spm_stall,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [DATA_W-1:0] cfg_pattern,
  input  logic              cfg_incr,
  output logic              busy,
  output logic              done_irq,
  output logic [ADDR_W:0]   remain
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  fill_state_e       state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [DATA_W-1:0] cur_data, cur_data_nxt;
  logic [ADDR_W:0]   remain_nxt;
  logic [SW-1:0]     starve_cnt, starve_cnt_nxt;
  logic              incr_r, incr_nxt;

  logic mem_req;
  logic forced;
  logic eng_wr;

  // An aborting cycle never writes, so it never needs to stall MEM either.
  assign mem_req = (mem_spm_as_ == ENABLE_);
  assign forced  = (state == ST_FILL) && !cfg_abort && mem_req &&
                   (starve_cnt == STARVE_LIM);
  assign eng_wr  = (state == ST_FILL) && !cfg_abort && (!mem_req || forced);

  always_comb begin
    spm_addr      = mem_spm_addr;
    spm_as_       = mem_spm_as_;
    spm_rw        = mem_spm_rw;
    spm_wr_data   = mem_spm_wr_data;
    mem_spm_stall = 1'b0;
    if (reset) begin
      spm_as_ = DISABLE_;
      spm_rw  = READ;
    end else if (eng_wr) begin
      spm_addr      = cur_addr;
      spm_as_       = ENABLE_;
      spm_rw        = WRITE;
      spm_wr_data   = cur_data;
      mem_spm_stall = forced;
    end
  end

  assign mem_spm_rd_data = spm_rd_data;
  assign busy            = (state == ST_FILL);
  assign done_irq        = (state == ST_DONE);

  always_comb begin
    state_nxt      = state;
    cur_addr_nxt   = cur_addr;
    cur_data_nxt   = cur_data;
    remain_nxt     = remain;
    starve_cnt_nxt = '0;
    incr_nxt       = incr_r;
    unique case (state)
      ST_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          cur_addr_nxt = cfg_base;
          cur_data_nxt = cfg_pattern;
          remain_nxt   = cfg_len;
          incr_nxt     = cfg_incr;
          state_nxt    = (cfg_len == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else if (eng_wr) begin
          cur_addr_nxt = cur_addr + 1'b1;
          cur_data_nxt = cur_data + DATA_W'(incr_r);
          remain_nxt   = remain - 1'b1;
          if (remain == (ADDR_W+1)'(1)) state_nxt = ST_DONE;
        end else begin
          starve_cnt_nxt = starve_cnt + 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      cur_data   <= '0;
      remain     <= '0;
      starve_cnt <= '0;
      incr_r     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      cur_data   <= cur_data_nxt;
      remain     <= remain_nxt;
      starve_cnt <= starve_cnt_nxt;
      incr_r     <= incr_nxt;
    end
  end

endmodule

// File: tb/tb_spm_fill_ctrl.sv
// Directed bench for spm_fill_ctrl: per-cycle vector table plus hand-written
// starvation and mid-fill reset sequences against a small SPM model.
module tb_spm_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] mem_spm_addr;
  logic        mem_spm_as_;
  logic        mem_spm_rw;
  logic [31:0] mem_spm_wr_data;
  logic [31:0] mem_spm_rd_data;
  logic        mem_spm_stall;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;
  logic        cfg_start, cfg_abort, cfg_incr;
  logic [11:0] cfg_base;
  logic [12:0] cfg_len;
  logic [31:0] cfg_pattern;
  logic        busy, done_irq;
  logic [12:0] remain;

  always #5 clk = ~clk;

  spm_fill_ctrl #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .mem_spm_addr(mem_spm_addr), .mem_spm_as_(mem_spm_as_), .mem_spm_rw(mem_spm_rw),
    .mem_spm_wr_data(mem_spm_wr_data), .mem_spm_rd_data(mem_spm_rd_data),
    .mem_spm_stall(mem_spm_stall),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_pattern(cfg_pattern), .cfg_incr(cfg_incr),
    .busy(busy), .done_irq(done_irq), .remain(remain)
  );

  // SPM model: writes land in a sparse array, reads return one cycle later.
  logic [31:0] spm_mem [int];
  logic [31:0] model_rd = 32'h0;
  logic [31:0] tv_rd;
  logic        use_model = 1'b0;
  logic        count_wr  = 1'b0;
  int          wr_seen   = 0;

  assign spm_rd_data = use_model ? model_rd : tv_rd;

  always @(posedge clk) begin
    if (spm_as_ == 1'b0 && spm_rw == 1'b0) begin
      spm_mem[int'(spm_addr)] = spm_wr_data;
      if (count_wr) wr_seen++;
    end
    if (spm_as_ == 1'b0 && spm_rw == 1'b1)
      model_rd <= spm_mem.exists(int'(spm_addr)) ? spm_mem[int'(spm_addr)]
                                                 : (32'hC0DE_0000 | 32'(spm_addr));
  end

  typedef struct {
    logic        mas, mrw;
    logic [11:0] maddr;
    logic [31:0] mwd;
    logic        st, ab;
    logic [11:0] base;
    logic [12:0] len;
    logic [31:0] pat;
    logic        inc;
    logic [31:0] rd;
    logic        e_as, e_rw;
    logic [11:0] e_addr;
    logic [31:0] e_wd;
    logic        e_stall, e_busy, e_done;
    logic [12:0] e_rem;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(logic mas, logic mrw, logic [11:0] maddr, logic [31:0] mwd,
                              logic st, logic ab, logic [11:0] base, logic [12:0] len,
                              logic [31:0] pat, logic inc, logic [31:0] rd,
                              logic e_as, logic e_rw, logic [11:0] e_addr, logic [31:0] e_wd,
                              logic e_stall, logic e_busy, logic e_done, logic [12:0] e_rem);
    vec_t v;
    v.mas = mas; v.mrw = mrw; v.maddr = maddr; v.mwd = mwd; v.st = st; v.ab = ab;
    v.base = base; v.len = len; v.pat = pat; v.inc = inc; v.rd = rd;
    v.e_as = e_as; v.e_rw = e_rw; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_busy = e_busy; v.e_done = e_done; v.e_rem = e_rem;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    mem_spm_as_ = 1'b1; mem_spm_rw = 1'b1; mem_spm_addr = '0; mem_spm_wr_data = '0;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_base = '0; cfg_len = '0;
    cfg_pattern = '0; cfg_incr = 1'b0; tv_rd = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // mas mrw maddr mwd | st ab base len pat inc rd | as rw addr wd stall busy done rem
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(0,1,12'h123,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'hDEADBEEF, 0,1,12'h123,32'h0,        0,0,0,13'd0);
    add(0,0,12'h456,32'h11112222, 0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h456,32'h11112222, 0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        1,0,12'h010,13'd4,32'hA5A50000,1,32'h0, 1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h010,32'hA5A50000, 0,1,0,13'd4);
    add(1,1,12'h000,32'h0,        1,0,12'h300,13'd7,32'h0,0,32'h0,        0,0,12'h011,32'hA5A50001, 0,1,0,13'd3);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h012,32'hA5A50002, 0,1,0,13'd2);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h013,32'hA5A50003, 0,1,0,13'd1);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,1,13'd0);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        1,0,12'h020,13'd2,32'h5,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(0,1,12'h050,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h12345678, 0,1,12'h050,32'h0,        0,1,0,13'd2);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h020,32'h5,        0,1,0,13'd2);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h021,32'h5,        0,1,0,13'd1);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,1,13'd0);
    add(1,1,12'h000,32'h0,        1,0,12'h700,13'd0,32'h99,0,32'h0,       1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,1,13'd0);
    add(1,1,12'h000,32'h0,        1,1,12'h800,13'd3,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        1,0,12'hFFE,13'd4,32'h77,0,32'h0,       1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'hFFE,32'h77,       0,1,0,13'd4);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'hFFF,32'h77,       0,1,0,13'd3);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h000,32'h77,       0,1,0,13'd2);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h001,32'h77,       0,1,0,13'd1);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,1,13'd0);
    add(1,1,12'h000,32'h0,        1,0,12'h100,13'd100,32'h0,1,32'h0,      1,1,12'h000,32'h0,        0,0,0,13'd0);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h100,32'h0,        0,1,0,13'd100);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        0,0,12'h101,32'h1,        0,1,0,13'd99);
    add(1,1,12'h000,32'h0,        0,1,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,1,0,13'd98);
    add(1,1,12'h000,32'h0,        0,1,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd98);
    add(1,1,12'h000,32'h0,        0,0,12'h000,13'd0,32'h0,0,32'h0,        1,1,12'h000,32'h0,        0,0,0,13'd98);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      mem_spm_as_ = tbl[i].mas; mem_spm_rw = tbl[i].mrw; mem_spm_addr = tbl[i].maddr;
      mem_spm_wr_data = tbl[i].mwd; cfg_start = tbl[i].st; cfg_abort = tbl[i].ab;
      cfg_base = tbl[i].base; cfg_len = tbl[i].len; cfg_pattern = tbl[i].pat;
      cfg_incr = tbl[i].inc; tv_rd = tbl[i].rd;
      #1;
      chk($sformatf("r%0d spm_as_", i), 32'(spm_as_), 32'(tbl[i].e_as));
      chk($sformatf("r%0d spm_rw", i), 32'(spm_rw), 32'(tbl[i].e_rw));
      chk($sformatf("r%0d spm_addr", i), 32'(spm_addr), 32'(tbl[i].e_addr));
      chk($sformatf("r%0d spm_wr_data", i), spm_wr_data, tbl[i].e_wd);
      chk($sformatf("r%0d stall", i), 32'(mem_spm_stall), 32'(tbl[i].e_stall));
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("r%0d done_irq", i), 32'(done_irq), 32'(tbl[i].e_done));
      chk($sformatf("r%0d remain", i), 32'(remain), 32'(tbl[i].e_rem));
      chk($sformatf("r%0d rd_data", i), mem_spm_rd_data, tbl[i].rd);
    end

    // Starvation: MEM strobes every cycle, engine gets a forced slot every 17th.
    @(negedge clk);
    idle_inputs();
    mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 12'h7FF;
    cfg_start = 1'b1; cfg_base = 12'h400; cfg_len = 13'd8;
    cfg_pattern = 32'h10; cfg_incr = 1'b1;
    for (int c = 1; c <= 138; c++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      if (c % 17 == 0 && c <= 136) begin
        chk($sformatf("starve c%0d stall", c), 32'(mem_spm_stall), 32'd1);
        chk($sformatf("starve c%0d as_rw", c), {30'd0, spm_as_, spm_rw}, 32'd0);
        chk($sformatf("starve c%0d addr", c), 32'(spm_addr), 32'h400 + 32'(c / 17 - 1));
        chk($sformatf("starve c%0d data", c), spm_wr_data, 32'h10 + 32'(c / 17 - 1));
      end else begin
        chk($sformatf("starve c%0d stall", c), 32'(mem_spm_stall), 32'd0);
        chk($sformatf("starve c%0d mem_addr", c), 32'(spm_addr), 32'h7FF);
      end
      chk($sformatf("starve c%0d done_irq", c), 32'(done_irq), (c == 137) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a fill, then read back an untouched word.
    @(negedge clk);
    idle_inputs();
    use_model = 1'b1;
    cfg_start = 1'b1; cfg_base = 12'h200; cfg_len = 13'd50;
    cfg_pattern = 32'hAAAA0000; cfg_incr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      cfg_start = 1'b0;
    end
    #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    count_wr = 1'b1;
    #1;
    chk("in-reset spm_as_", 32'(spm_as_), 32'd1);
    chk("in-reset stall", 32'(mem_spm_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset remain", 32'(remain), 32'd0);
    chk("post-reset spm_as_", 32'(spm_as_), 32'd1);
    @(negedge clk);
    mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 12'h210;
    #1;
    chk("mem read as_", 32'(spm_as_), 32'd0);
    chk("mem read addr", 32'(spm_addr), 32'h210);
    @(negedge clk);
    mem_spm_as_ = 1'b1;
    #1;
    chk("mem read data", mem_spm_rd_data, 32'hC0DE0210);
    repeat (4) @(negedge clk);
    chk("writes after reset", 32'(wr_seen), 32'd0);
    chk("fill word 0x202", spm_mem.exists(32'h202) ? spm_mem[32'h202] : 32'hX, 32'hAAAA0002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
